muldiv_unit: RTL
================

# muldiv_unit

Iterative multiply/divide unit for the MIPS EX stage, executing MULT, MULTU, DIV and DIVU and owning the architectural HI/LO registers. While an operation is in flight it raises `stall`, which drives the hazard unit's ALUStall input and freezes PC, IF/ID, ID/EX, EX/MEM and MEM/WB. Results are written to HI/LO; MFHI/MFLO read them through the `hi`/`lo` outputs, and MTHI/MTLO write them directly.

## Interface
- WIDTH, 32, operand width; iteration count equals WIDTH
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- op_valid  in  1  EX-stage instruction is MULT/MULTU/DIV/DIVU
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- rs_val  in  WIDTH  forwarded rs operand (multiplicand / dividend)
- rt_val  in  WIDTH  forwarded rt operand (multiplier / divisor)
- pipe_stall  in  1  pipeline held by another source (CacheStall)
- mthi  in  1  write wdata to HI
- mtlo  in  1  write wdata to LO
- wdata  in  WIDTH  MTHI/MTLO data
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- stall  out  1  to hazard ALUStall
- busy  out  1  state is BUSY

## Operation
- States: IDLE, BUSY, DONE.
- IDLE and op_valid: latch op, take magnitudes of the operands (signed ops only), record the result signs, clear the counter, and go to BUSY.
- BUSY: one iteration per cycle.
  - Multiply: shift-add into a 2·WIDTH accumulator.
  - Divide: restoring shift-subtract with a WIDTH+1-bit partial remainder.
- Counter reaches WIDTH-1: write HI/LO and go to DONE.
  - MULT/MULTU: HI = product[63:32], LO = product[31:0].
  - DIV/DIVU: LO = quotient, HI = remainder.
- Sign rules:
  - Product is negated if the operand signs differ.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - All arithmetic is two's complement, mod 2^WIDTH per half.
- Divide by zero (signed or unsigned): LO = all ones, HI = dividend. The divide still takes the full latency.
- Signed overflow (−2^31 / −1): LO = 0x80000000, HI = 0. This falls out of the magnitude path with no special case.
- DONE: op_valid is ignored, because the completed instruction is still in EX.
  - DONE goes to IDLE when pipe_stall = 0.
  - DONE stays in DONE while pipe_stall = 1.
- mthi/mtlo are honoured only in IDLE or DONE. If op_valid starts an operation in the same IDLE cycle, the MT write still lands; the later result overwrites it.
- mthi/mtlo are ignored in BUSY. This cannot occur while the pipeline is frozen.
- pipe_stall during BUSY has no effect; iteration continues.

## Timing
- Reset: state IDLE, hi = 0, lo = 0, stall = 0, busy = 0, counter = 0.
- stall = (IDLE and op_valid) or BUSY. It is combinational in the start cycle so the hazard unit freezes the pipeline in that same cycle.
- Start cycle S. stall is high for cycles S through S+WIDTH (33 cycles).
- HI/LO are written at the edge ending cycle S+WIDTH and are visible at S+WIDTH+1.
- At S+WIDTH+1 the unit is in DONE and stall = 0, so the instruction retires from EX.
- Back-to-back ops: a second mult/div reaches EX at S+WIDTH+2 in IDLE and starts immediately.
- An MFHI/MFLO directly after the op sees the new value, with no extra stall.
- rst asserted mid-operation: next cycle IDLE, HI/LO = 0, stall = 0. The partial result is discarded.
- rs_val/rt_val are sampled only in the start cycle. Later changes are ignored.

## Structure
- Package muldiv_pkg holds:
  - the op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU);
  - the state enum (IDLE, BUSY, DONE);
  - the default WIDTH.
- Sub-module muldiv_datapath holds the accumulator, partial remainder, counter and the final sign fix. It is controlled by load/step/finish strobes from the FSM in muldiv_unit.
- HI/LO registers and the MT write logic live in the top.

## Test plan
- MULT 0xFFFFFFFE × 0x00000003: stall high 33 cycles, then HI = 0xFFFFFFFF, LO = 0xFFFFFFFA.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF: HI = 0xFFFFFFFE, LO = 0x00000001.
- DIV −7 / 2: LO = 0xFFFFFFFD (−3), HI = 0xFFFFFFFF (−1).
- DIVU 100 / 0: LO = 0xFFFFFFFF, HI = 100, stall for the full 33 cycles.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- Completion with pipe_stall held 3 cycles and op_valid still high: unit stays in DONE, no restart, stall = 0. Then MTLO 0x1234 in IDLE gives lo = 0x1234 next cycle.
- rst at iteration 10: next cycle stall = 0, hi = lo = 0, state IDLE.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op encodings, FSM states and default width for the multiply/divide unit
package muldiv_pkg;
    localparam int WIDTH_DEF = 32;
    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/muldiv_datapath.sv
// muldiv_datapath: magnitude shift-add multiplier / restoring divider with final sign fix
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             last,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);
    localparam int CW = $clog2(WIDTH);
    logic [2*WIDTH-1:0] acc_q, acc_d, mul_nx, prod;
    logic [WIDTH:0]     rem_q, rem_d, sh, rem_nx, sum;
    logic [WIDTH-1:0]   opnd_q, opnd_d, mag_a, mag_b, q_nx, rem_mag;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               div_q, div_d, neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
    logic               sgn, sa, sb, ge;
    always_comb begin
        sgn     = (op == OP_MULT) || (op == OP_DIV);
        sa      = sgn & rs_val[WIDTH-1];
        sb      = sgn & rt_val[WIDTH-1];
        mag_a   = sa ? -rs_val : rs_val;
        mag_b   = sb ? -rt_val : rt_val;
        sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_nx  = {sum, acc_q[WIDTH-1:1]};
        sh      = {rem_q[WIDTH-1:0], acc_q[WIDTH-1]};
        ge      = sh >= {1'b0, opnd_q};
        rem_nx  = ge ? sh - {1'b0, opnd_q} : sh;
        q_nx    = {acc_q[WIDTH-2:0], ge};
        // results are taken from the post-step values so HI/LO land on the last iteration's edge
        prod    = neg_lo_q ? -mul_nx : mul_nx;
        rem_mag = rem_nx[WIDTH-1:0];
        res_hi  = div_q ? (neg_hi_q ? -rem_mag : rem_mag) : prod[2*WIDTH-1:WIDTH];
        res_lo  = div_q ? (neg_lo_q ? -q_nx : q_nx) : prod[WIDTH-1:0];
        last    = cnt_q == CW'(WIDTH - 1);
        acc_d    = acc_q;
        rem_d    = rem_q;
        opnd_d   = opnd_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        if (load) begin
            div_d    = (op == OP_DIV) || (op == OP_DIVU);
            opnd_d   = div_d ? mag_b : mag_a;
            acc_d    = {{WIDTH{1'b0}}, div_d ? mag_a : mag_b};
            rem_d    = '0;
            cnt_d    = '0;
            // divide by zero keeps the all-ones quotient unsigned-looking
            neg_lo_d = (sa ^ sb) & ~(div_d & (rt_val == '0));
            neg_hi_d = sa;
        end else if (step) begin
            acc_d = div_q ? {acc_q[2*WIDTH-1:WIDTH], q_nx} : mul_nx;
            rem_d = div_q ? rem_nx : rem_q;
            cnt_d = cnt_q + CW'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            rem_q    <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
            div_q    <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            opnd_q   <= opnd_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
        end
    end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU unit owning HI/LO and stalling the pipeline while busy
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             pipe_stall,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             stall,
    output logic             busy
);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, res_hi, res_lo;
    logic             load, step, finish, last, mt_ok;
    muldiv_datapath #(.WIDTH(WIDTH)) u_dp (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .step   (step),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .last   (last),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );
    always_comb begin
        load    = (state_q == IDLE) && op_valid;
        step    = state_q == BUSY;
        finish  = step && last;
        state_d = load ? BUSY : finish ? DONE : (state_q == DONE && !pipe_stall) ? IDLE : state_q;
        mt_ok   = state_q != BUSY;
        hi_d    = finish ? res_hi : (mthi && mt_ok) ? wdata : hi_q;
        lo_d    = finish ? res_lo : (mtlo && mt_ok) ? wdata : lo_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end
    assign stall = load || step;
    assign busy  = step;
    assign hi    = hi_q;
    assign lo    = lo_q;
endmodule
